id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Captures decoded instruction fields and register-file read data.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Drives the ALU's operand1, operand2 and alu_control from registers, and carries rd, reg_write, store data and PC down the pipe with a valid/ready handshake and a flush.

Parameters:
- XLEN, 32, datapath width of operands, PC and forwarded data.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_pc  input  XLEN  instruction PC
- in_rs1  input  REG_ADDR_W  source register 1 index
- in_rs2  input  REG_ADDR_W  source register 2 index
- in_rd  input  REG_ADDR_W  destination index
- in_rs1_data  input  XLEN  regfile read for rs1
- in_rs2_data  input  XLEN  regfile read for rs2
- in_imm  input  XLEN  sign-extended immediate
- in_op1_sel  input  1  0 = rs1 value, 1 = PC
- in_op2_sel  input  1  0 = rs2 value, 1 = immediate
- in_alu_control  input  4  ALU op code (0000 AND ... 1001 XOR)
- in_reg_write  input  1  instruction writes rd
- flush  input  1  kill held and incoming instruction
- fwd_mem_valid  input  1  MEM stage writes a register
- fwd_mem_rd  input  REG_ADDR_W  MEM destination
- fwd_mem_data  input  XLEN  MEM result
- fwd_wb_valid  input  1  WB stage writes a register
- fwd_wb_rd  input  REG_ADDR_W  WB destination
- fwd_wb_data  input  XLEN  WB result
- out_valid  output  1  execute-stage contents valid
- out_ready  input  1  downstream accepts
- operand1  output  XLEN  to ALU operand1
- operand2  output  XLEN  to ALU operand2
- alu_control  output  4  to ALU alu_control
- out_rs2_value  output  XLEN  forwarded rs2 value (store data), independent of op2_sel
- out_rd  output  REG_ADDR_W  destination index
- out_reg_write  output  1  write enable, gated by out_valid
- out_pc  output  XLEN  PC of held instruction

Behaviour:
- Reset (rst_n low, async):
  - out_valid = 0 and all data outputs = 0; alu_control = 0000.
  - in_ready = 1 once reset is released.
- in_ready = !out_valid || out_ready || flush. This is combinational, with no combinational path from in_valid.
- Capture (latency 1 cycle): when in_valid && in_ready && !flush, register all fields on the next edge and set out_valid = 1.
- Drain: out_valid clears on out_valid && out_ready with no new capture.
- Back-to-back: capture and drain in the same cycle keeps out_valid = 1 and loads the new instruction.
- Flush: out_valid = 0 on the next edge regardless of in_valid and out_ready.
  - An incoming beat in the flush cycle is consumed (in_ready = 1) and discarded.
  - Data registers may keep stale values, but out_reg_write must read 0.
- Forwarding at capture, per source rsN (rs1, rs2):
  - If rsN != 0 and fwd_mem_valid && fwd_mem_rd == rsN, use fwd_mem_data.
  - Else if fwd_wb_valid && fwd_wb_rd == rsN, use fwd_wb_data.
  - Else use in_rsN_data.
  - MEM has priority over WB. x0 is never forwarded and always reads the regfile value.
- Operand select: operand1 = op1_sel ? pc : fwd_rs1; operand2 = op2_sel ? imm : fwd_rs2. The selection is applied at capture.
- Hold snoop: while out_valid && !out_ready, re-apply the forwarding rules each cycle to the held rs1/rs2 values, using stored indices.
  - Update only the operands whose select is 0. Always update out_rs2_value.
  - This keeps operands correct when producers retire during a stall.
- Simultaneous snoop and drain: drain wins, and the snoop result is irrelevant.
- Reset asserted mid-operation immediately clears out_valid and the outputs.
- No arithmetic is performed in this block. Width rules are pass-through only.

Test Plan:
- Reset, then a single beat with rs1 = 3, data 0x10, op2_sel = 1, imm = 0x5, alu_control = 0010 -> one cycle later out_valid = 1, operand1 = 0x10, operand2 = 0x5, alu_control = 0010.
- Capture rs1 = 4 with fwd_mem_valid, rd = 4, data 0xAA and fwd_wb_valid, rd = 4, data 0xBB -> operand1 = 0xAA (MEM priority).
- Capture rs2 = 0 with fwd_mem_rd = 0, data 0xFFFF and in_rs2_data = 0 -> operand2 = 0.
- Hold with out_ready = 0 on an instruction with rs1 = 7 (captured value 0x1); next cycle fwd_wb_valid, rd = 7, data 0x99 -> operand1 becomes 0x99 while out_valid stays 1 and in_ready = 0.
- Flush while holding, with in_valid = 1 in the same cycle -> next cycle out_valid = 0, out_reg_write = 0, incoming beat dropped.
- Continuous in_valid = 1 and out_ready = 1 for 4 beats -> 4 outputs in order, one per cycle, in_ready constantly 1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded fields with MEM/WB
// forwarding, and re-snoops the forwarding buses while stalled.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_op1_sel,
    input  logic                  in_op2_sel,
    input  logic [3:0]            in_alu_control,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  fwd_mem_valid,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_valid,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       operand1,
    output logic [XLEN-1:0]       operand2,
    output logic [3:0]            alu_control,
    output logic [XLEN-1:0]       out_rs2_value,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic [XLEN-1:0]       out_pc
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic                  sel1_q, sel2_q, reg_write_q;
    logic [XLEN-1:0]       pc_q, op1_q, op2_q, rs2v_q;
    logic [3:0]            alu_q;

    logic                  capture, hold;
    logic [XLEN-1:0]       cap_rs1, cap_rs2, snp_rs1, snp_rs2;

    // MEM beats WB; x0 is hardwired and never forwarded.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [XLEN-1:0]       base,
        input logic                  mem_v,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [XLEN-1:0]       mem_d,
        input logic                  wb_v,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_d
    );
        if (rs != '0 && mem_v && mem_rd == rs)
            return mem_d;
        else if (rs != '0 && wb_v && wb_rd == rs)
            return wb_d;
        else
            return base;
    endfunction

    assign in_ready = !valid_q || out_ready || flush;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready && !flush;

    always_comb begin
        cap_rs1 = fwd_pick(in_rs1, in_rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        cap_rs2 = fwd_pick(in_rs2, in_rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        // While stalled, operand1 (when sel=0) and rs2v_q hold the register values.
        snp_rs1 = fwd_pick(rs1_q, op1_q, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        snp_rs2 = fwd_pick(rs2_q, rs2v_q, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                           fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            sel1_q      <= 1'b0;
            sel2_q      <= 1'b0;
            reg_write_q <= 1'b0;
            pc_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rs2v_q      <= '0;
            alu_q       <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (capture)
                valid_q <= 1'b1;
            else if (valid_q && out_ready)
                valid_q <= 1'b0;

            if (capture) begin
                rs1_q       <= in_rs1;
                rs2_q       <= in_rs2;
                rd_q        <= in_rd;
                sel1_q      <= in_op1_sel;
                sel2_q      <= in_op2_sel;
                reg_write_q <= in_reg_write;
                pc_q        <= in_pc;
                alu_q       <= in_alu_control;
                op1_q       <= in_op1_sel ? in_pc : cap_rs1;
                op2_q       <= in_op2_sel ? in_imm : cap_rs2;
                rs2v_q      <= cap_rs2;
            end else if (hold) begin
                if (!sel1_q) op1_q <= snp_rs1;
                if (!sel2_q) op2_q <= snp_rs2;
                rs2v_q <= snp_rs2;
            end
        end
    end

    assign out_valid     = valid_q;
    assign operand1      = op1_q;
    assign operand2      = op2_q;
    assign alu_control   = alu_q;
    assign out_rs2_value = rs2v_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q && valid_q;
    assign out_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [RW-1:0]   in_rs1, in_rs2, in_rd;
    logic            in_op1_sel, in_op2_sel, in_reg_write, flush;
    logic [3:0]      in_alu_control;
    logic            fwd_mem_valid, fwd_wb_valid;
    logic [RW-1:0]   fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic            out_valid, out_ready, out_reg_write;
    logic [XLEN-1:0] operand1, operand2, out_rs2_value, out_pc;
    logic [3:0]      alu_control;
    logic [RW-1:0]   out_rd;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the instruction currently held in execute.
    logic            m_valid;
    logic [RW-1:0]   m_rs1, m_rs2, m_rd;
    logic            m_sel1, m_sel2, m_rw;
    logic [XLEN-1:0] m_pc, m_imm, m_r1, m_r2;
    logic [3:0]      m_alu;

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
        .in_alu_control(in_alu_control), .in_reg_write(in_reg_write), .flush(flush),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .operand1(operand1),
        .operand2(operand2), .alu_control(alu_control), .out_rs2_value(out_rs2_value),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Value a source register should read given the forwarding buses right now.
    function automatic logic [XLEN-1:0] model_read(input logic [RW-1:0] rs, input logic [XLEN-1:0] reg_val);
        if (rs == 0) return reg_val;
        if (fwd_mem_valid && fwd_mem_rd == rs) return fwd_mem_data;
        if (fwd_wb_valid && fwd_wb_rd == rs) return fwd_wb_data;
        return reg_val;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_sel1 = 0; m_sel2 = 0; m_rw = 0;
        m_pc = 0; m_imm = 0; m_r1 = 0; m_r2 = 0; m_alu = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_op1_sel = 0; in_op2_sel = 0;
        in_alu_control = 0; in_reg_write = 0; flush = 0; out_ready = 0;
        fwd_mem_valid = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_valid = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    endtask

    // Inputs are already driven (we are just past a negedge). Check in_ready,
    // advance the model over one edge, then check the outputs.
    task automatic cycle();
        logic exp_ready;
        exp_ready = !m_valid || out_ready || flush;
        #1;
        chk("in_ready", in_ready, exp_ready);
        if (flush) begin
            m_valid = 0;
        end else if (in_valid && exp_ready) begin
            m_valid = 1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
            m_sel1 = in_op1_sel; m_sel2 = in_op2_sel; m_rw = in_reg_write;
            m_pc = in_pc; m_imm = in_imm; m_alu = in_alu_control;
            m_r1 = model_read(in_rs1, in_rs1_data);
            m_r2 = model_read(in_rs2, in_rs2_data);
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            m_r1 = model_read(m_rs1, m_r1);
            m_r2 = model_read(m_rs2, m_r2);
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_reg_write", out_reg_write, m_valid && m_rw);
        if (m_valid) begin
            chk("operand1", operand1, m_sel1 ? m_pc : m_r1);
            chk("operand2", operand2, m_sel2 ? m_imm : m_r2);
            chk("rs2_value", out_rs2_value, m_r2);
            chk("alu_control", alu_control, m_alu);
            chk("out_rd", out_rd, m_rd);
            chk("out_pc", out_pc, m_pc);
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic [RW-1:0] rs1, input logic [XLEN-1:0] d1,
                        input logic [RW-1:0] rs2, input logic [XLEN-1:0] d2,
                        input logic s1, input logic s2, input logic [XLEN-1:0] imm,
                        input logic [3:0] alu, input logic [RW-1:0] rd, input logic [XLEN-1:0] pc);
        in_valid = 1; in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
        in_op1_sel = s1; in_op2_sel = s2; in_imm = imm; in_alu_control = alu;
        in_rd = rd; in_pc = pc; in_reg_write = 1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_operand1", operand1, 0);
        chk("rst_operand2", operand2, 0);
        chk("rst_alu", alu_control, 0);
        chk("rst_reg_write", out_reg_write, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Single beat with immediate operand2
        out_ready = 0;
        beat(3, 32'h10, 1, 32'h77, 0, 1, 32'h5, 4'b0010, 9, 32'h100);
        cycle();
        chk("tp1_op1", operand1, 32'h10);
        chk("tp1_op2", operand2, 32'h5);
        chk("tp1_alu", alu_control, 4'b0010);

        // MEM wins over WB
        out_ready = 1;
        beat(4, 32'h1, 2, 32'h2, 0, 0, 0, 4'b0000, 5, 32'h104);
        fwd_mem_valid = 1; fwd_mem_rd = 4; fwd_mem_data = 32'hAA;
        fwd_wb_valid = 1; fwd_wb_rd = 4; fwd_wb_data = 32'hBB;
        cycle();
        chk("tp2_mem_prio", operand1, 32'hAA);

        // x0 never forwarded
        beat(1, 32'h3, 0, 32'h0, 0, 0, 0, 4'b0001, 6, 32'h108);
        fwd_mem_rd = 0; fwd_mem_data = 32'hFFFF; fwd_wb_valid = 0;
        cycle();
        chk("tp3_x0", operand2, 32'h0);

        // Hold snoop: WB retires rs1 during a stall
        fwd_mem_valid = 0;
        beat(7, 32'h1, 2, 32'h2, 0, 0, 0, 4'b0011, 8, 32'h10C);
        cycle();
        in_valid = 0; out_ready = 0;
        fwd_wb_valid = 1; fwd_wb_rd = 7; fwd_wb_data = 32'h99;
        cycle();
        chk("tp4_snoop_op1", operand1, 32'h99);
        chk("tp4_held", out_valid, 1);
        #1 chk("tp4_in_ready", in_ready, 0);
        fwd_wb_valid = 0;

        // Flush while holding, with an incoming beat
        beat(1, 32'h5, 2, 32'h6, 0, 0, 0, 4'b0100, 10, 32'h200);
        flush = 1;
        cycle();
        flush = 0; in_valid = 0;
        cycle();
        chk("tp5_dropped", out_valid, 0);

        // Four back-to-back beats
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            beat(RW'(i + 1), 32'h1000 + i, 0, 0, 0, 1, 32'(i), 4'(i), RW'(i + 11), 32'h300 + 4 * i);
            cycle();
            chk("tp6_order_pc", out_pc, 32'h300 + 4 * i);
        end
        in_valid = 0;
        cycle();

        // Randomized traffic with occasional async reset
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = $urandom; in_imm = $urandom;
            in_rs1 = RW'($urandom_range(0, 7)); in_rs2 = RW'($urandom_range(0, 7));
            in_rd = RW'($urandom_range(0, 31));
            in_rs1_data = $urandom; in_rs2_data = $urandom;
            in_op1_sel = 1'($urandom); in_op2_sel = 1'($urandom);
            in_alu_control = 4'($urandom_range(0, 9)); in_reg_write = 1'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            out_ready = 1'($urandom);
            fwd_mem_valid = 1'($urandom); fwd_mem_rd = RW'($urandom_range(0, 7));
            fwd_mem_data = $urandom;
            fwd_wb_valid = 1'($urandom); fwd_wb_rd = RW'($urandom_range(0, 7));
            fwd_wb_data = $urandom;
            if (n % 97 == 50) begin
                #2 rst_n = 0;
                #1;
                chk("midrst_valid", out_valid, 0);
                chk("midrst_op1", operand1, 0);
                chk("midrst_pc", out_pc, 0);
                model_reset();
                @(negedge clk);
                rst_n = 1;
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
